somador_subtrator_serial_c1: RTL and testbench

SOMADOR_SUBTRATOR_SERIAL_C1 -- requirements
Module: somador_subtrator_serial_c1

---
 rtl/somador_subtrator_serial_c1.sv | 137 +++++++++++++
 tb/tb_somador_subtrator_serial_c1.sv | 120 ++++++++++++
 2 files changed

// File: rtl/somador_subtrator_serial_c1.sv
// Bit-serial one's complement adder/subtractor.
// One bit per cycle, LSB first, in SOMA; when the sum produces an end-around
// carry, a second serial pass (CORRECAO) adds it back in.
// Results are published only when the operation reaches FIM, so s, cout,
// overflow and zero keep the previous operation's values while a new one runs.
module somador_subtrator_serial_c1 #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sinal,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         overflow,
    output logic         zero,
    output logic         busy,
    output logic         done
);
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, SOMA, CORRECAO, FIM} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, b_q, acc_q;
    logic           carry_q;
    logic [IW-1:0]  idx_q;
    logic           eac_q;
    logic [N-1:0]   s_q;
    logic           cout_q, ovf_q, zero_q;

    logic           x_bit, y_bit, sum_bit, cy_bit, last_bit;
    logic [N-1:0]   acc_upd;

    // Shared 1-bit full adder: SOMA adds a+b', CORRECAO adds the carry into acc
    always_comb begin
        x_bit    = (state_q == SOMA) ? a_q[idx_q] : acc_q[idx_q];
        y_bit    = (state_q == SOMA) ? b_q[idx_q] : 1'b0;
        sum_bit  = x_bit ^ y_bit ^ carry_q;
        cy_bit   = (x_bit & y_bit) | (x_bit & carry_q) | (y_bit & carry_q);
        acc_upd  = acc_q;
        acc_upd[idx_q] = sum_bit;
        last_bit = (idx_q == LAST);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start) state_d = SOMA;
            SOMA:     if (last_bit) state_d = cy_bit ? CORRECAO : FIM;
            CORRECAO: if (last_bit) state_d = FIM;
            FIM:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy     = (state_q == SOMA) || (state_q == CORRECAO);
        done     = (state_q == FIM);
        s        = s_q;
        cout     = cout_q;
        overflow = ovf_q;
        zero     = zero_q;
    end

    // Operand capture, serial datapath and result publication on entry to FIM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            eac_q   <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b ^ {N{sinal}};
                        acc_q   <= '0;
                        carry_q <= 1'b0;
                        idx_q   <= '0;
                    end
                end
                SOMA: begin
                    acc_q <= acc_upd;
                    if (last_bit) begin
                        idx_q   <= '0;
                        eac_q   <= cy_bit;
                        // Seed the correction pass with the end-around carry
                        carry_q <= 1'b1;
                        if (!cy_bit) begin
                            s_q    <= acc_upd;
                            cout_q <= 1'b0;
                            ovf_q  <= (a_q[N-1] == b_q[N-1]) && (acc_upd[N-1] != a_q[N-1]);
                            zero_q <= (&acc_upd) | ~(|acc_upd);
                        end
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        carry_q <= cy_bit;
                    end
                end
                CORRECAO: begin
                    // Carry out of the correction pass is intentionally dropped
                    acc_q   <= acc_upd;
                    carry_q <= cy_bit;
                    if (last_bit) begin
                        idx_q  <= '0;
                        s_q    <= acc_upd;
                        cout_q <= eac_q;
                        ovf_q  <= (a_q[N-1] == b_q[N-1]) && (acc_upd[N-1] != a_q[N-1]);
                        zero_q <= (&acc_upd) | ~(|acc_upd);
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_somador_subtrator_serial_c1.sv
// Self-checking bench: directed cases plus random operations compared against
// an arithmetic one's complement model; also start-during-busy and mid-op reset.
module tb_somador_subtrator_serial_c1;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sinal = 1'b0;
    logic [N-1:0] a = '0, b = '0;
    logic [N-1:0] s;
    logic         cout, overflow, zero, busy, done;

    int n_chk  = 0;
    int n_pass = 0;

    somador_subtrator_serial_c1 #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .sinal(sinal), .a(a), .b(b),
        .s(s), .cout(cout), .overflow(overflow), .zero(zero),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Runs one operation from an idle negedge; optionally pulses start with
    // junk operands 3 cycles in, which must have no effect.
    task automatic run_op(input logic [N-1:0] va, input logic [N-1:0] vb,
                          input logic vs, input bit glitch);
        logic [N:0]   sum9;
        logic [N-1:0] bb, res;
        logic         ec, ovf, zr;
        int           lat, cyc;
        bb   = vs ? ~vb : vb;
        sum9 = {1'b0, va} + {1'b0, bb};
        ec   = sum9[N];
        res  = sum9[N-1:0] + {{(N-1){1'b0}}, ec};
        ovf  = (va[N-1] == bb[N-1]) && (res[N-1] != va[N-1]);
        zr   = (res == '0) || (res == '1);
        lat  = ec ? 2*N + 1 : N + 1;

        @(negedge clk);
        a = va; b = vb; sinal = vs; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        chk("busy_after_accept", {31'b0, busy}, 32'd1);
        while (!done && cyc < 4*N) begin
            a = N'($urandom); b = N'($urandom); sinal = 1'($urandom);
            start = glitch && (cyc == 3);
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        chk("latency", cyc, lat);
        chk("s", {24'b0, s}, {24'b0, res});
        chk("cout", {31'b0, cout}, {31'b0, ec});
        chk("overflow", {31'b0, overflow}, {31'b0, ovf});
        chk("zero", {31'b0, zero}, {31'b0, zr});
        chk("busy_at_done", {31'b0, busy}, 32'd0);
        @(negedge clk);
        chk("done_one_cycle", {31'b0, done}, 32'd0);
        chk("s_hold", {24'b0, s}, {24'b0, res});
    endtask

    initial begin
        logic [N-1:0] ra, rb;
        bit           seen_done;
        #1;
        chk("rst_s", {24'b0, s}, 32'd0);
        chk("rst_flags", {27'b0, cout, overflow, zero, busy, done}, 32'd0);
        #20 rst = 1'b0;

        run_op(8'h05, 8'h03, 1'b0, 1'b0);
        run_op(8'h05, 8'h03, 1'b1, 1'b0);
        run_op(8'h03, 8'h05, 1'b1, 1'b0);
        run_op(8'h05, 8'h05, 1'b1, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 1'b0);
        run_op(8'h80, 8'h80, 1'b0, 1'b0);
        run_op(8'h05, 8'h03, 1'b1, 1'b1);
        run_op(8'h05, 8'h03, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            ra = N'($urandom); rb = N'($urandom);
            run_op(ra, rb, 1'($urandom), (i % 5) == 0);
        end

        // Abort mid-operation: outputs clear at once, no done follows
        run_op(8'h21, 8'h10, 1'b0, 1'b0);
        @(negedge clk);
        a = 8'h05; b = 8'h03; sinal = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_s", {24'b0, s}, 32'd0);
        chk("midrst_flags", {27'b0, cout, overflow, zero, busy, done}, 32'd0);
        seen_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen_done |= done;
        end
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen_done |= done;
        end
        chk("no_done_after_rst", {31'b0, seen_done}, 32'd0);
        run_op(8'h80, 8'h80, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
